// File: rtl/gb_cpu_fetch_ctrl_if.sv
// Sequencer/decoder-facing bundle of the fetch controller: fetch strobe, opcode bus,
// instruction-side pulses, IE/IF views and the decoder/IRQ outputs.
interface gb_cpu_fetch_ctrl_if #(
    parameter int NUM_IRQ = 5
);
    logic               fetch_en;
    logic [7:0]         mem_rdata;
    logic               cb_exec;
    logic               halt_exec;
    logic               ei_exec;
    logic               di_exec;
    logic               reti_exec;
    logic [NUM_IRQ-1:0] ie;
    logic [NUM_IRQ-1:0] if_flags;
    logic [7:0]         opcode;
    logic               cb_prefix;
    logic               isr_cmd;
    logic [7:0]         isr_vector;
    logic [NUM_IRQ-1:0] if_clr;
    logic               pc_inc;
    logic               ime;
    logic               halted;

    modport master (
        output fetch_en, mem_rdata, cb_exec, halt_exec, ei_exec, di_exec, reti_exec,
               ie, if_flags,
        input  opcode, cb_prefix, isr_cmd, isr_vector, if_clr, pc_inc, ime, halted
    );

    modport slave (
        input  fetch_en, mem_rdata, cb_exec, halt_exec, ei_exec, di_exec, reti_exec,
               ie, if_flags,
        output opcode, cb_prefix, isr_cmd, isr_vector, if_clr, pc_inc, ime, halted
    );
endinterface

// File: rtl/gb_cpu_fetch_ctrl.sv
// Fetch/IRQ-dispatch controller: IR latch, IME + EI delay, HALT, priority IRQ select; GB_CPU_HALT_BUG_EN adds the DMG HALT bug.
// All outputs registered on the fetch_en edge (pulses last one cycle); no backpressure, sequencer stalls while halted.
module gb_cpu_fetch_ctrl #(
    parameter int         NUM_IRQ      = 5,
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    gb_cpu_fetch_ctrl_if.slave bus
);
    typedef enum logic {ST_RUN, ST_HALT} state_e;

    state_e             state_q, state_d;
    logic [7:0]         opcode_q, opcode_d;
    logic               cb_q, cb_d;
    logic               isr_q, isr_d;
    logic [7:0]         vec_q, vec_d;
    logic [NUM_IRQ-1:0] if_clr_q, if_clr_d;
    logic               pc_inc_q, pc_inc_d;
    logic               ime_q, ime_d;
    logic               ei_s1_q, ei_s1_d;
    logic               ei_s2_q, ei_s2_d;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic [7:0]         irq_vec;
    logic               ime_eff;
    logic               irq_ok;
    logic               halt_bug;

    assign pending = bus.ie & bus.if_flags;
    assign ime_eff = ime_q | ei_s2_q;
    assign irq_ok  = ime_eff & (|pending) & ~bus.cb_exec;

`ifdef GB_CPU_HALT_BUG_EN
    // HALT with interrupts disabled but already pending: fetch proceeds, PC does not advance
    assign halt_bug = bus.halt_exec & ~ime_eff & (|pending);
`else
    assign halt_bug = 1'b0;
`endif

    // Scan from the top so the lowest pending index (highest priority) wins
    always_comb begin
        irq_onehot = '0;
        irq_vec    = 8'h40;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
                irq_vec       = 8'h40 + 8'(i * 8);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        cb_d     = cb_q;
        isr_d    = isr_q;
        vec_d    = vec_q;
        if_clr_d = '0;
        pc_inc_d = 1'b0;
        ime_d    = ime_q;
        ei_s1_d  = ei_s1_q;
        ei_s2_d  = ei_s2_q;
        case (state_q)
            ST_RUN: begin
                if (bus.fetch_en) begin
                    ei_s2_d = ei_s1_q;
                    ei_s1_d = 1'b0;
                    if (ei_s2_q) begin
                        ime_d = 1'b1;
                    end
                    if (bus.halt_exec && !(|pending)) begin
                        state_d = ST_HALT;
                    end else if (irq_ok) begin
                        // Opcode byte is latched but not consumed; it is refetched after RETI
                        isr_d    = 1'b1;
                        cb_d     = 1'b0;
                        opcode_d = bus.mem_rdata;
                        vec_d    = irq_vec;
                        if_clr_d = irq_onehot;
                        ime_d    = 1'b0;
                        ei_s1_d  = 1'b0;
                        ei_s2_d  = 1'b0;
                    end else begin
                        opcode_d = bus.mem_rdata;
                        cb_d     = bus.cb_exec;
                        isr_d    = 1'b0;
                        pc_inc_d = ~halt_bug;
                    end
                end
            end
            ST_HALT: begin
                if (|pending) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (bus.ei_exec) begin
            ei_s1_d = 1'b1;
        end
        if (bus.reti_exec) begin
            ime_d = 1'b1;
        end
        // DI wins over EI and RETI landing on the same edge
        if (bus.di_exec) begin
            ime_d   = 1'b0;
            ei_s1_d = 1'b0;
            ei_s2_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            opcode_q <= RESET_OPCODE;
            cb_q     <= 1'b0;
            isr_q    <= 1'b0;
            vec_q    <= 8'h40;
            if_clr_q <= '0;
            pc_inc_q <= 1'b0;
            ime_q    <= 1'b0;
            ei_s1_q  <= 1'b0;
            ei_s2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cb_q     <= cb_d;
            isr_q    <= isr_d;
            vec_q    <= vec_d;
            if_clr_q <= if_clr_d;
            pc_inc_q <= pc_inc_d;
            ime_q    <= ime_d;
            ei_s1_q  <= ei_s1_d;
            ei_s2_q  <= ei_s2_d;
        end
    end

    assign bus.opcode     = opcode_q;
    assign bus.cb_prefix  = cb_q;
    assign bus.isr_cmd    = isr_q;
    assign bus.isr_vector = vec_q;
    assign bus.if_clr     = if_clr_q;
    assign bus.pc_inc     = pc_inc_q;
    assign bus.ime        = ime_q;
    assign bus.halted     = (state_q == ST_HALT);
endmodule

// File: tb/tb_gb_cpu_fetch_ctrl.sv
// Bench for gb_cpu_fetch_ctrl: directed scenarios plus randomized traffic against an instruction-level model.
module tb_gb_cpu_fetch_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    gb_cpu_fetch_ctrl_if #(.NUM_IRQ(5)) bus ();

    gb_cpu_fetch_ctrl #(.NUM_IRQ(5), .RESET_OPCODE(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: tracks architectural effects per instruction boundary
    logic [7:0] m_opcode, m_vec;
    logic       m_cb, m_isr, m_pc_inc, m_ime, m_halted;
    logic [4:0] m_if_clr;
    int         fetch_cnt;
    int         ei_q[$];

    function automatic logic [25:0] dut_obs();
        return {bus.opcode, bus.cb_prefix, bus.isr_cmd, bus.isr_vector, bus.if_clr,
                bus.pc_inc, bus.ime, bus.halted};
    endfunction

    function automatic logic [25:0] exp_obs();
        return {m_opcode, m_cb, m_isr, m_vec, m_if_clr, m_pc_inc, m_ime, m_halted};
    endfunction

    task automatic model_edge();
        logic [4:0] pend;
        bit         ei_on, eff, disp, bug;
        int         idx;
        if (reset) begin
            m_opcode = 8'h00; m_cb = 0; m_isr = 0; m_vec = 8'h40; m_if_clr = '0;
            m_pc_inc = 0; m_ime = 0; m_halted = 0; fetch_cnt = 0; ei_q.delete();
            return;
        end
        pend     = bus.ie & bus.if_flags;
        m_pc_inc = 0;
        m_if_clr = '0;
        disp     = 0;
        // An EI enables interrupts at the second instruction boundary after it is seen
        ei_on = 0;
        foreach (ei_q[k]) if (ei_q[k] == fetch_cnt - 1) ei_on = 1;
        eff = m_ime || ei_on;
        if (m_halted) begin
            if (pend != 0) m_halted = 0;
        end else if (bus.fetch_en) begin
            if (bus.halt_exec && pend == 0) begin
                m_halted = 1;
            end else if (eff && pend != 0 && !bus.cb_exec) begin
                disp = 1;
                idx = 0;
                for (int i = 4; i >= 0; i--) if (pend[i]) idx = i;
                m_isr = 1; m_cb = 0; m_opcode = bus.mem_rdata;
                m_vec = 8'h40 + 8'(idx * 8);
                m_if_clr = 5'b00001 << idx;
                m_ime = 0;
                ei_q.delete();
            end else begin
                bug = 0;
`ifdef GB_CPU_HALT_BUG_EN
                bug = bus.halt_exec && !eff && pend != 0;
`endif
                m_opcode = bus.mem_rdata; m_cb = bus.cb_exec; m_isr = 0; m_pc_inc = !bug;
            end
            if (!disp && ei_on) m_ime = 1;
            fetch_cnt++;
            while (ei_q.size() > 0 && ei_q[0] < fetch_cnt - 1) void'(ei_q.pop_front());
        end
        if (bus.ei_exec) ei_q.push_back(fetch_cnt);
        if (bus.reti_exec) m_ime = 1;
        if (bus.di_exec) begin
            m_ime = 0;
            ei_q.delete();
        end
    endtask

    task automatic cyc(input bit fe, input logic [7:0] rd, input bit cb, input bit hl,
                       input bit ei, input bit di, input bit rt);
        bus.fetch_en = fe; bus.mem_rdata = rd; bus.cb_exec = cb; bus.halt_exec = hl;
        bus.ei_exec = ei; bus.di_exec = di; bus.reti_exec = rt;
        @(posedge clk);
        model_edge();
        #1;
        bus.fetch_en = 0; bus.cb_exec = 0; bus.halt_exec = 0;
        bus.ei_exec = 0; bus.di_exec = 0; bus.reti_exec = 0;
    endtask

    task automatic apply_reset();
        bus.ie = '0; bus.if_flags = '0;
        reset = 1'b1;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (dut_obs() !== {8'h00, 1'b0, 1'b0, 8'h40, 5'b0, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got %h, want %h", dut_obs(),
                     {8'h00, 1'b0, 1'b0, 8'h40, 5'b0, 3'b000});
        end
    endtask

    task automatic test_fetch();
        logic [10:0] got;
        apply_reset();
        cyc(1, 8'h3E, 0, 0, 0, 0, 0);
        got = {bus.opcode, bus.cb_prefix, bus.isr_cmd, bus.pc_inc};
        tests_run++;
        if (got !== {8'h3E, 3'b001}) begin
            tests_failed++;
            $display("FAIL fetch_basic: got %h, want %h", got, {8'h3E, 3'b001});
        end
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        tests_run++;
        if (bus.pc_inc !== 1'b0 || bus.opcode !== 8'h3E) begin
            tests_failed++;
            $display("FAIL fetch_pulse: got pc_inc=%b op=%h, want 0 3e", bus.pc_inc, bus.opcode);
        end
    endtask

    task automatic test_cb_irq();
        logic [10:0] got;
        logic [16:0] isr;
        apply_reset();
        cyc(0, 8'h00, 0, 0, 0, 0, 1);
        bus.ie = 5'h01; bus.if_flags = 5'h01;
        cyc(1, 8'h7C, 1, 0, 0, 0, 0);
        got = {bus.opcode, bus.cb_prefix, bus.isr_cmd, bus.pc_inc};
        tests_run++;
        if (got !== {8'h7C, 3'b101} || bus.ime !== 1'b1) begin
            tests_failed++;
            $display("FAIL cb_no_isr: got %h ime=%b, want %h ime=1", got, bus.ime, {8'h7C, 3'b101});
        end
        cyc(1, 8'h55, 0, 0, 0, 0, 0);
        isr = {bus.isr_cmd, bus.isr_vector, bus.if_clr, bus.ime, bus.pc_inc, bus.cb_prefix};
        tests_run++;
        if (isr !== {1'b1, 8'h40, 5'b00001, 3'b000}) begin
            tests_failed++;
            $display("FAIL isr_vblank: got %h, want %h", isr, {1'b1, 8'h40, 5'b00001, 3'b000});
        end
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        tests_run++;
        if (bus.if_clr !== 5'b0) begin
            tests_failed++;
            $display("FAIL if_clr_pulse: got %b, want 00000", bus.if_clr);
        end
    endtask

    task automatic test_ei_delay();
        apply_reset();
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        bus.ie = 5'h1F; bus.if_flags = 5'h06;
        cyc(1, 8'h11, 0, 0, 0, 0, 0);
        tests_run++;
        if ({bus.isr_cmd, bus.ime, bus.pc_inc, bus.opcode} !== {3'b001, 8'h11}) begin
            tests_failed++;
            $display("FAIL ei_first_fetch: got isr=%b ime=%b pc_inc=%b op=%h, want 0 0 1 11",
                     bus.isr_cmd, bus.ime, bus.pc_inc, bus.opcode);
        end
        cyc(1, 8'h22, 0, 0, 0, 0, 0);
        tests_run++;
        if ({bus.isr_cmd, bus.isr_vector, bus.if_clr, bus.ime} !== {1'b1, 8'h48, 5'b00010, 1'b0}) begin
            tests_failed++;
            $display("FAIL ei_second_isr: got isr=%b vec=%h clr=%b ime=%b, want 1 48 00010 0",
                     bus.isr_cmd, bus.isr_vector, bus.if_clr, bus.ime);
        end
    endtask

    task automatic test_halt_wake();
        apply_reset();
        cyc(1, 8'h3E, 0, 0, 0, 0, 0);
        cyc(1, 8'h99, 0, 1, 0, 0, 0);
        tests_run++;
        if ({bus.halted, bus.opcode, bus.pc_inc} !== {1'b1, 8'h3E, 1'b0}) begin
            tests_failed++;
            $display("FAIL halt_enter: got halted=%b op=%h pc_inc=%b, want 1 3e 0",
                     bus.halted, bus.opcode, bus.pc_inc);
        end
        cyc(1, 8'hAA, 0, 0, 0, 0, 0);
        tests_run++;
        if ({bus.halted, bus.opcode, bus.pc_inc} !== {1'b1, 8'h3E, 1'b0}) begin
            tests_failed++;
            $display("FAIL halt_ignores_fetch: got halted=%b op=%h pc_inc=%b, want 1 3e 0",
                     bus.halted, bus.opcode, bus.pc_inc);
        end
        bus.ie = 5'h10; bus.if_flags = 5'h10;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        tests_run++;
        if (bus.halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_wake: got halted=%b, want 0", bus.halted);
        end
        cyc(1, 8'h77, 0, 0, 0, 0, 0);
        tests_run++;
        if ({bus.isr_cmd, bus.pc_inc, bus.opcode} !== {2'b01, 8'h77}) begin
            tests_failed++;
            $display("FAIL wake_fetch: got isr=%b pc_inc=%b op=%h, want 0 1 77",
                     bus.isr_cmd, bus.pc_inc, bus.opcode);
        end
    endtask

    task automatic test_halt_bug();
        logic exp_pc;
`ifdef GB_CPU_HALT_BUG_EN
        exp_pc = 1'b0;
`else
        exp_pc = 1'b1;
`endif
        apply_reset();
        bus.ie = 5'h04; bus.if_flags = 5'h04;
        cyc(1, 8'h5A, 0, 1, 0, 0, 0);
        tests_run++;
        if ({bus.halted, bus.isr_cmd, bus.opcode, bus.pc_inc} !== {2'b00, 8'h5A, exp_pc}) begin
            tests_failed++;
            $display("FAIL halt_pending: got halted=%b isr=%b op=%h pc_inc=%b, want 0 0 5a %b",
                     bus.halted, bus.isr_cmd, bus.opcode, bus.pc_inc, exp_pc);
        end
    endtask

    task automatic test_ei_di();
        apply_reset();
        cyc(0, 8'h00, 0, 0, 1, 1, 0);
        bus.ie = 5'h01; bus.if_flags = 5'h01;
        for (int n = 0; n < 2; n++) begin
            cyc(1, 8'h10 + 8'(n), 0, 0, 0, 0, 0);
            tests_run++;
            if (bus.isr_cmd !== 1'b0 || bus.ime !== 1'b0) begin
                tests_failed++;
                $display("FAIL ei_di_fetch%0d: got isr=%b ime=%b, want 0 0", n, bus.isr_cmd, bus.ime);
            end
        end
        cyc(0, 8'h00, 0, 0, 0, 1, 1);
        tests_run++;
        if (bus.ime !== 1'b0) begin
            tests_failed++;
            $display("FAIL di_beats_reti: got ime=%b, want 0", bus.ime);
        end
        bus.ie = '0; bus.if_flags = '0;
        cyc(1, 8'h3E, 0, 0, 0, 0, 0);
        cyc(1, 8'h76, 0, 1, 0, 0, 0);
        tests_run++;
        if (bus.halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL halt_before_reset: got halted=%b, want 1", bus.halted);
        end
        reset = 1'b1;
        cyc(0, 8'h00, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tests_run++;
        if (bus.halted !== 1'b0 || bus.opcode !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_in_halt: got halted=%b op=%h, want 0 00", bus.halted, bus.opcode);
        end
    endtask

    task automatic test_random();
        bit fe, cb, hl;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                bus.ie       = 5'($urandom);
                bus.if_flags = 5'($urandom) & 5'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            fe = ($urandom_range(0, 9) < 4);
            cb = fe && ($urandom_range(0, 9) == 0);
            hl = fe && !cb && ($urandom_range(0, 11) == 0);
            cyc(fe, 8'($urandom), cb, hl, $urandom_range(0, 19) == 0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);
            tests_run++;
            if (dut_obs() !== exp_obs()) begin
                tests_failed++;
                $display("FAIL random_cycle%0d: got %h, want %h", n, dut_obs(), exp_obs());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.fetch_en = 0; bus.mem_rdata = '0; bus.cb_exec = 0; bus.halt_exec = 0;
        bus.ei_exec = 0; bus.di_exec = 0; bus.reti_exec = 0; bus.ie = '0; bus.if_flags = '0;
        test_reset();
        test_fetch();
        test_cb_irq();
        test_ei_delay();
        test_halt_wake();
        test_halt_bug();
        test_ei_di();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
